// File: rtl/ama_riscv_pipe_ctrl_if.sv
// Pipeline control bus for ama_riscv_pipe_ctrl.
// master: the core side that presents hazard/flush/dmem status and consumes controls.
// slave:  the sequencing controller.
interface ama_riscv_pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // ID / EX hazard sources
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_load;
    logic             ex_reg_we;
    logic [4:0]       ex_rd_addr;
    logic             ex_flush;
    // MEM stage dmem handshake
    logic             mem_req;
    logic             dmem_ready;
    // Pipeline register controls
    logic             pc_we;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             clear_id;
    logic             clear_ex;
    logic             clear_mem;
    logic             mem_err;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_load, ex_reg_we, ex_rd_addr, ex_flush,
        output mem_req, dmem_ready,
        input  pc_we, stall_if, stall_id, stall_ex, stall_mem,
        input  clear_id, clear_ex, clear_mem, mem_err,
        input  perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_load, ex_reg_we, ex_rd_addr, ex_flush,
        input  mem_req, dmem_ready,
        output pc_we, stall_if, stall_id, stall_ex, stall_mem,
        output clear_id, clear_ex, clear_mem, mem_err,
        output perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline sequencing controller for the AMA-RISCV 5-stage core.
// Drives stall/clear of the IF/ID/EX/MEM registers and the PC write enable:
// post-reset clear sequence, load-use bubbles, control-flow flushes and dmem
// wait freezes. Outputs are Mealy; priority in RUN is mem wait > flush > load-use.
// Optional perf counters: define AMA_RISCV_PIPE_CTRL_PERF_CNT_EN to build them,
// otherwise the counter ports read as zero.
module ama_riscv_pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input logic                  clk,
    input logic                  rst,      // asynchronous, active-low
    ama_riscv_pipe_ctrl_if.slave ctrl_if
);

    typedef enum logic [1:0] {
        StRstSeq  = 2'd0,
        StRun     = 2'd1,
        StMemWait = 2'd2
    } state_e;

    localparam logic [16:0] TimeoutVal = 17'(MEM_TIMEOUT);

    state_e      state_q;
    logic [2:0]  rst_seq_q;
    logic [15:0] wait_cnt_q;
    logic [16:0] wait_cnt_inc;
    logic        mem_err_q;

    logic load_use;
    logic freeze;
    logic eval_run;

    logic pc_we;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic clear_id;
    logic clear_ex;
    logic clear_mem;

    // A load whose rd feeds the ID instruction; x0 never hazards.
    assign load_use = ctrl_if.ex_load && ctrl_if.ex_reg_we && (ctrl_if.ex_rd_addr != 5'd0) &&
                      ((ctrl_if.id_rs1_used && (ctrl_if.id_rs1_addr == ctrl_if.ex_rd_addr)) ||
                       (ctrl_if.id_rs2_used && (ctrl_if.id_rs2_addr == ctrl_if.ex_rd_addr)));

    // In MEM_WAIT the freeze holds on dmem_ready alone; mem_req is frozen with the pipe.
    assign freeze = ((state_q == StRun) && ctrl_if.mem_req && !ctrl_if.dmem_ready) ||
                    ((state_q == StMemWait) && !ctrl_if.dmem_ready);

    // Cycles where flush/hazard inputs are honoured (RUN, or the MEM_WAIT release cycle).
    assign eval_run = (state_q != StRstSeq) && !freeze;

    assign wait_cnt_inc = {1'b0, wait_cnt_q} + 17'd1;

    // Sequencing state: reset shifter, FSM, dmem wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRstSeq;
            rst_seq_q  <= 3'b111;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            rst_seq_q <= {rst_seq_q[1:0], 1'b0};
            case (state_q)
                StRstSeq: begin
                    if (rst_seq_q[1:0] == 2'b00) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (freeze) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= '0;
                    end
                end
                StMemWait: begin
                    if (wait_cnt_q != 16'hffff) begin
                        wait_cnt_q <= wait_cnt_inc[15:0];
                    end
                    if (wait_cnt_inc >= TimeoutVal) begin
                        mem_err_q <= 1'b1;
                    end
                    if (ctrl_if.dmem_ready) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRstSeq;
            endcase
        end
    end

    // Mealy stall/clear decode, highest-priority condition first.
    always_comb begin
        pc_we     = 1'b1;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        clear_id  = 1'b0;
        clear_ex  = 1'b0;
        clear_mem = 1'b0;
        if (state_q == StRstSeq) begin
            clear_id  = rst_seq_q[0];
            clear_ex  = rst_seq_q[1];
            clear_mem = rst_seq_q[2];
        end else if (freeze) begin
            pc_we     = 1'b0;
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (ctrl_if.ex_flush) begin
            // Squashes the ID instruction, so any load-use hazard is moot.
            clear_id = 1'b1;
            clear_ex = 1'b1;
        end else if (load_use) begin
            pc_we    = 1'b0;
            stall_if = 1'b1;
            stall_id = 1'b1;
            clear_ex = 1'b1;
        end
    end

    assign ctrl_if.pc_we     = pc_we;
    assign ctrl_if.stall_if  = stall_if;
    assign ctrl_if.stall_id  = stall_id;
    assign ctrl_if.stall_ex  = stall_ex;
    assign ctrl_if.stall_mem = stall_mem;
    assign ctrl_if.clear_id  = clear_id;
    assign ctrl_if.clear_ex  = clear_ex;
    assign ctrl_if.clear_mem = clear_mem;
    assign ctrl_if.mem_err   = mem_err_q;

`ifdef AMA_RISCV_PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             flush_accept;

    assign flush_accept = eval_run && ctrl_if.ex_flush;

    // Saturating perf counters; stall_if is never set during the reset sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_accept && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ctrl_if.perf_stall_cnt = stall_cnt_q;
    assign ctrl_if.perf_flush_cnt = flush_cnt_q;
`else
    assign ctrl_if.perf_stall_cnt = {CNT_W{1'b0}};
    assign ctrl_if.perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ama_riscv_pipe_ctrl.sv
// Self-checking bench for ama_riscv_pipe_ctrl (MEM_TIMEOUT = 8).
// Each row is driven just after a rising edge; the expected control vector is
// queued then and compared on the following falling edge.
module tb_ama_riscv_pipe_ctrl;

    localparam int unsigned CNT_W = 32;

    // {pc_we, stall_if, stall_id, stall_ex, stall_mem, clear_id, clear_ex, clear_mem, mem_err}
    localparam logic [8:0] E_NORM   = 9'b1_0000_000_0;
    localparam logic [8:0] E_FREEZE = 9'b0_1111_000_0;
    localparam logic [8:0] E_FLUSH  = 9'b1_0000_110_0;
    localparam logic [8:0] E_LU     = 9'b0_1100_010_0;
    localparam logic [8:0] E_RST111 = 9'b1_0000_111_0;
    localparam logic [8:0] E_RST110 = 9'b1_0000_011_0;
    localparam logic [8:0] E_RST100 = 9'b1_0000_001_0;
    localparam logic [8:0] E_ERR    = 9'b0_0000_000_1;

    typedef struct packed {
        logic       rst;
        logic       ex_load;
        logic       ex_reg_we;
        logic [4:0] ex_rd_addr;
        logic [4:0] id_rs1_addr;
        logic [4:0] id_rs2_addr;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic       ex_flush;
        logic       mem_req;
        logic       dmem_ready;
    } stim_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ama_riscv_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ama_riscv_pipe_ctrl #(
        .MEM_TIMEOUT(8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_if(bus)
    );

    logic [8:0]       exp_q[$];
    int               n_pass  = 0;
    int               n_total = 0;
    logic [CNT_W-1:0] mdl_stall = '0;
    logic [CNT_W-1:0] mdl_flush = '0;

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t hz(logic [4:0] rd, logic [4:0] rs1, logic u1,
                                 logic [4:0] rs2, logic u2);
        stim_t s;
        s             = idle();
        s.ex_load     = 1'b1;
        s.ex_reg_we   = 1'b1;
        s.ex_rd_addr  = rd;
        s.id_rs1_addr = rs1;
        s.id_rs1_used = u1;
        s.id_rs2_addr = rs2;
        s.id_rs2_used = u2;
        return s;
    endfunction

    function automatic stim_t wait_row(logic rdy);
        stim_t s;
        s            = idle();
        s.mem_req    = 1'b1;
        s.dmem_ready = rdy;
        return s;
    endfunction

    function automatic logic [8:0] observe();
        return {bus.pc_we, bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                bus.clear_id, bus.clear_ex, bus.clear_mem, bus.mem_err};
    endfunction

    function automatic logic [CNT_W-1:0] want_cnt(logic [CNT_W-1:0] mdl);
`ifdef AMA_RISCV_PIPE_CTRL_PERF_CNT_EN
        return mdl;
`else
        return (mdl & '0);
`endif
    endfunction

    task automatic apply(stim_t s);
        @(posedge clk);
        #1;
        rst             = s.rst;
        bus.ex_load     = s.ex_load;
        bus.ex_reg_we   = s.ex_reg_we;
        bus.ex_rd_addr  = s.ex_rd_addr;
        bus.id_rs1_addr = s.id_rs1_addr;
        bus.id_rs2_addr = s.id_rs2_addr;
        bus.id_rs1_used = s.id_rs1_used;
        bus.id_rs2_used = s.id_rs2_used;
        bus.ex_flush    = s.ex_flush;
        bus.mem_req     = s.mem_req;
        bus.dmem_ready  = s.dmem_ready;
        if (!s.rst) begin
            mdl_stall = '0;
            mdl_flush = '0;
        end
    endtask

    // Scoreboard push plus perf model: stall_if cycles and accepted flushes.
    task automatic expect_row(logic [8:0] e);
        exp_q.push_back(e);
        if (e[7]) mdl_stall = mdl_stall + 1;
        if (e[3:1] == 3'b110) mdl_flush = mdl_flush + 1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [8:0] e[$];
        logic [8:0] got, want;
        stim_t t;
        t = idle(); t.rst = 1'b0;
        s.push_back(t);                        e.push_back(E_RST111);
        s.push_back(t);                        e.push_back(E_RST111);
        t = idle(); t.ex_flush = 1'b1;
        s.push_back(t);                        e.push_back(E_RST111);
        s.push_back(hz(5'd5, 5'd0, 1'b0, 5'd5, 1'b1)); e.push_back(E_RST110);
        s.push_back(wait_row(1'b0));           e.push_back(E_RST100);
        s.push_back(idle());                   e.push_back(E_NORM);
        s.push_back(idle());                   e.push_back(E_NORM);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            expect_row(e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL reset row %0d: got %b want %b", i, got, want);
            else n_pass++;
        end
        n_total++;
        if (bus.perf_stall_cnt !== want_cnt(mdl_stall))
            $display("FAIL reset stall_cnt: got %0d want %0d", bus.perf_stall_cnt,
                     want_cnt(mdl_stall));
        else n_pass++;
        n_total++;
        if (bus.perf_flush_cnt !== want_cnt(mdl_flush))
            $display("FAIL reset flush_cnt: got %0d want %0d", bus.perf_flush_cnt,
                     want_cnt(mdl_flush));
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        stim_t s[$];
        logic [8:0] e[$];
        logic [8:0] got, want;
        stim_t t;
        s.push_back(wait_row(1'b0));           e.push_back(E_FREEZE);
        t = wait_row(1'b0); t.ex_flush = 1'b1;
        s.push_back(t);                        e.push_back(E_FREEZE);
        t = hz(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); t.mem_req = 1'b1;
        s.push_back(t);                        e.push_back(E_FREEZE);
        s.push_back(wait_row(1'b0));           e.push_back(E_FREEZE);
        s.push_back(wait_row(1'b1));           e.push_back(E_NORM);
        s.push_back(idle());                   e.push_back(E_NORM);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            expect_row(e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL mem_wait row %0d: got %b want %b", i, got, want);
            else n_pass++;
        end
        n_total++;
        if (bus.perf_stall_cnt !== want_cnt(mdl_stall))
            $display("FAIL mem_wait stall_cnt: got %0d want %0d", bus.perf_stall_cnt,
                     want_cnt(mdl_stall));
        else n_pass++;
        n_total++;
        if (bus.perf_flush_cnt !== want_cnt(mdl_flush))
            $display("FAIL mem_wait flush_cnt: got %0d want %0d", bus.perf_flush_cnt,
                     want_cnt(mdl_flush));
        else n_pass++;
    endtask

    task automatic test_release_reeval();
        stim_t s[$];
        logic [8:0] e[$];
        logic [8:0] got, want;
        stim_t t;
        s.push_back(wait_row(1'b0));           e.push_back(E_FREEZE);
        t = hz(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); t.ex_flush = 1'b1; t.dmem_ready = 1'b1;
        s.push_back(t);                        e.push_back(E_FLUSH);
        s.push_back(wait_row(1'b0));           e.push_back(E_FREEZE);
        t = hz(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); t.dmem_ready = 1'b1;
        s.push_back(t);                        e.push_back(E_LU);
        s.push_back(idle());                   e.push_back(E_NORM);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            expect_row(e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL release row %0d: got %b want %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [8:0] e[$];
        logic [8:0] got, want;
        stim_t t;
        s.push_back(hz(5'd5, 5'd0, 1'b0, 5'd5, 1'b1));   e.push_back(E_LU);
        s.push_back(idle());                             e.push_back(E_NORM);
        s.push_back(hz(5'd0, 5'd0, 1'b1, 5'd0, 1'b1));   e.push_back(E_NORM);
        s.push_back(hz(5'd7, 5'd7, 1'b1, 5'd0, 1'b0));   e.push_back(E_LU);
        s.push_back(hz(5'd7, 5'd7, 1'b0, 5'd7, 1'b0));   e.push_back(E_NORM);
        t = hz(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); t.ex_load = 1'b0;
        s.push_back(t);                                  e.push_back(E_NORM);
        t = hz(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); t.ex_reg_we = 1'b0;
        s.push_back(t);                                  e.push_back(E_NORM);
        s.push_back(hz(5'd31, 5'd31, 1'b1, 5'd3, 1'b1)); e.push_back(E_LU);
        s.push_back(hz(5'd9, 5'd8, 1'b1, 5'd10, 1'b1));  e.push_back(E_NORM);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            expect_row(e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL load_use row %0d: got %b want %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        logic [8:0] e[$];
        logic [8:0] got, want;
        stim_t t;
        t = idle(); t.ex_flush = 1'b1;
        s.push_back(t);                        e.push_back(E_FLUSH);
        t = hz(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); t.ex_flush = 1'b1;
        s.push_back(t);                        e.push_back(E_FLUSH);
        s.push_back(idle());                   e.push_back(E_NORM);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            expect_row(e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL flush row %0d: got %b want %b", i, got, want);
            else n_pass++;
        end
        n_total++;
        if (bus.perf_flush_cnt !== want_cnt(mdl_flush))
            $display("FAIL flush flush_cnt: got %0d want %0d", bus.perf_flush_cnt,
                     want_cnt(mdl_flush));
        else n_pass++;
        n_total++;
        if (bus.perf_stall_cnt !== want_cnt(mdl_stall))
            $display("FAIL flush stall_cnt: got %0d want %0d", bus.perf_stall_cnt,
                     want_cnt(mdl_stall));
        else n_pass++;
    endtask

    task automatic test_timeout();
        stim_t s[$];
        logic [8:0] e[$];
        logic [8:0] got, want;
        stim_t t;
        // One RUN entry cycle, then 8 MEM_WAIT cycles before the flag shows.
        for (int k = 0; k < 9; k++) begin
            s.push_back(wait_row(1'b0));       e.push_back(E_FREEZE);
        end
        s.push_back(wait_row(1'b0));           e.push_back(E_FREEZE | E_ERR);
        s.push_back(wait_row(1'b1));           e.push_back(E_NORM | E_ERR);
        s.push_back(idle());                   e.push_back(E_NORM | E_ERR);
        s.push_back(wait_row(1'b0));           e.push_back(E_FREEZE | E_ERR);
        t = wait_row(1'b0); t.rst = 1'b0;
        s.push_back(t);                        e.push_back(E_RST111);
        s.push_back(idle());                   e.push_back(E_RST111);
        s.push_back(idle());                   e.push_back(E_RST110);
        s.push_back(idle());                   e.push_back(E_RST100);
        s.push_back(idle());                   e.push_back(E_NORM);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            expect_row(e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL timeout row %0d: got %b want %b", i, got, want);
            else n_pass++;
        end
        n_total++;
        if (bus.perf_stall_cnt !== want_cnt(mdl_stall))
            $display("FAIL timeout stall_cnt: got %0d want %0d", bus.perf_stall_cnt,
                     want_cnt(mdl_stall));
        else n_pass++;
    endtask

    initial begin
        rst             = 1'b0;
        bus.ex_load     = 1'b0;
        bus.ex_reg_we   = 1'b0;
        bus.ex_rd_addr  = '0;
        bus.id_rs1_addr = '0;
        bus.id_rs2_addr = '0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.ex_flush    = 1'b0;
        bus.mem_req     = 1'b0;
        bus.dmem_ready  = 1'b0;
        test_reset();
        test_mem_wait();
        test_release_reeval();
        test_load_use();
        test_flush();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ama_riscv_pipe_ctrl.md
# ama_riscv_pipe_ctrl

Pipeline sequencing controller for the AMA-RISCV 5-stage core. It sits beside the decoder and drives the stall and clear controls of the IF/ID/EX/MEM pipeline registers and the PC write enable. It owns the post-reset clear sequence, load-use hazard bubbles, control-flow flushes and data-memory wait freezes, with an optional pair of performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255 — max consecutive MEM_WAIT cycles before `mem_err` is set (1..65535).
- `CNT_W`, 32 — performance counter width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs1_addr`  in  5  rs1 of the instruction in ID.
- `id_rs2_addr`  in  5  rs2 of the instruction in ID.
- `id_rs1_used`  in  1  ID instruction reads rs1.
- `id_rs2_used`  in  1  ID instruction reads rs2.
- `ex_load`  in  1  EX instruction is a load.
- `ex_reg_we`  in  1  EX instruction writes rd.
- `ex_rd_addr`  in  5  rd of the EX instruction.
- `ex_flush`  in  1  EX resolved a taken jump or a mispredicted branch; PC redirect this cycle.
- `mem_req`  in  1  MEM stage issues a dmem access.
- `dmem_ready`  in  1  dmem completes the access this cycle.
- `pc_we`  out  1  PC register write enable.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`  out  1 each  hold the stage register.
- `clear_id`, `clear_ex`, `clear_mem`  out  1 each  load a bubble (NOP) into the stage register.
- `mem_err`  out  1  sticky dmem timeout flag.
- `perf_stall_cnt`  out  CNT_W  stall cycles.
- `perf_flush_cnt`  out  CNT_W  accepted flushes.

## Operation
- States: RST_SEQ, RUN, MEM_WAIT.
- 3-bit `rst_seq` register is forced to 3'b111 while `rst` is low. After release it shifts left with 0 fill on each clock: 111 → 110 → 100 → 000.
  - `clear_id` = `rst_seq[0]`, `clear_ex` = `rst_seq[1]`, `clear_mem` = `rst_seq[2]`.
  - The state is RST_SEQ while `rst_seq` != 0, then RUN.
  - In RST_SEQ: `pc_we`=1, all stalls 0, and all hazard, flush and mem inputs are ignored.
- Outputs are Mealy (state + inputs in the same cycle). Priority in RUN is: mem wait > flush > load-use > normal.
- Mem wait, when `mem_req & !dmem_ready`:
  - `stall_if/id/ex/mem` = 1, `pc_we` = 0, all clears = 0.
  - The next state is MEM_WAIT. It stays there while `dmem_ready` = 0.
  - In the cycle `dmem_ready` = 1, the freeze drops and the next state is RUN.
- Wait counter: cleared on entering MEM_WAIT, increments each MEM_WAIT cycle. On reaching `MEM_TIMEOUT`, `mem_err` is set and held until reset; the freeze continues.
- Flush, when `ex_flush`:
  - `clear_id` = 1, `clear_ex` = 1, `pc_we` = 1, stalls 0.
  - This overrides a simultaneous load-use hazard, because the hazarding instruction is squashed.
- Load-use hazard = `ex_load & ex_reg_we & (ex_rd_addr != 0) & ((id_rs1_used & id_rs1_addr == ex_rd_addr) | (id_rs2_used & id_rs2_addr == ex_rd_addr))`.
  - Response: `stall_if` = 1, `stall_id` = 1, `pc_we` = 0, `clear_ex` = 1.
  - Exactly one bubble; the hazard self-clears the next cycle.
- Normal: `pc_we` = 1, all stalls and clears 0.
- x0 as destination never creates a hazard.

## Timing
- Reset values (`rst` low): state RST_SEQ, `rst_seq` = 111, so `clear_id/ex/mem` = 1, stalls = 0, `pc_we` = 1, `mem_err` = 0, counters = 0.
- After release, `clear_id`, `clear_ex` and `clear_mem` stay high for 1, 2 and 3 cycles respectively.
- All stall and clear responses take effect combinationally in the cycle the condition is present (0-cycle latency). State, wait counter, `mem_err` and counters update on the next rising edge.
- `rst` asserted mid-operation (any state, including MEM_WAIT) immediately forces reset values asynchronously.
- `ex_flush` and hazard inputs during MEM_WAIT are ignored. They are held by the frozen pipe and re-evaluated in the release cycle.

## Configuration
- `AMA_RISCV_PIPE_CTRL_PERF_CNT_EN`:
  - Defined: `perf_stall_cnt` increments on every cycle with `stall_if` = 1 outside RST_SEQ. `perf_flush_cnt` increments on every accepted `ex_flush`. Both saturate at all-ones and reset to 0.
  - Undefined: both ports remain and are tied to 0, and no counter flops are built.

## Test plan
- Reset release: `rst` low for 2 cycles, then high → `clear_id`/`clear_ex`/`clear_mem` high for 1/2/3 cycles, `pc_we` = 1 throughout, stalls 0.
- Load-use: `ex_load` = 1, `ex_reg_we` = 1, `ex_rd_addr` = 5, `id_rs2_addr` = 5, `id_rs2_used` = 1 → one cycle of `stall_if` = `stall_id` = 1, `clear_ex` = 1, `pc_we` = 0.
  - Same stimulus with `ex_rd_addr` = 0 → no stall.
- Flush + hazard in the same cycle → `clear_id` = `clear_ex` = 1, `pc_we` = 1, no stalls; `perf_flush_cnt` +1 when the macro is defined.
- Mem wait: `mem_req` = 1, `dmem_ready` = 0 for 4 cycles, then 1 → all four stalls high for 4 cycles, released in cycle 5; `perf_stall_cnt` = 4.
- Timeout: `MEM_TIMEOUT` = 8, `dmem_ready` held at 0 → `mem_err` = 1 after 8 MEM_WAIT cycles; it stays 1 after `dmem_ready` = 1 and clears only on `rst` low.
